vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates pixel-rate timing from the 100 MHz system clock using an internal clock-enable divider, so no DCM-derived pixel clock is needed. It pulls pixels from the graphics block over a valid/ready handshake and drives the video DAC pins. Resolution, porches, sync polarity, colour depth, divider ratio and sync-on-green are all configurable; underflow is detected and reported.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
CLK_DIV, 4, system clocks per pixel (>=2)
COLOR_W, 8, bits per colour channel
SOG, 0, 1 = drive comp_sync as composite sync

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
pix_valid  in  1  graphics has a pixel on pix_data
pix_data  in  3*COLOR_W  {r,g,b}, r in MSBs
pix_ready  out  1  pixel consumed this cycle
underflow_clr  in  1  clears the sticky underflow flag
frame_start  out  1  one-clk pulse at the tick for h=0, v=0
underflow  out  1  sticky: active pixel had no valid data
h_count  out  clog2(H_TOTAL)  current horizontal position
v_count  out  clog2(V_TOTAL)  current vertical position
blank  out  1  active-low DAC blank (0 outside active region)
comp_sync  out  1  composite sync (see Behaviour)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
pixel_r / pixel_g / pixel_b  out  COLOR_W each  DAC colour

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (rst=0, async): divider, h_count and v_count clear to 0; pixel_r/g/b = 0; blank = 0; hsync = ~HS_POL; vsync = ~VS_POL; comp_sync = 1 when SOG=1, otherwise 0; pix_ready, frame_start and underflow = 0.
- Divider: counts 0..CLK_DIV-1. tick = (div == CLK_DIV-1). All timing state advances only on a tick.
- Counters: on each tick, h increments and wraps from H_TOTAL-1 to 0. On the h wrap, v increments and wraps from V_TOTAL-1 to 0.
- active = (h < H_ACTIVE) && (v < V_ACTIVE), evaluated on the current counter values.
- Handshake: pix_ready = tick & active & pix_valid, combinational and one clk wide. Graphics must hold pix_data stable while pix_valid=1 and not ready. Data is never consumed outside a tick.
- Output registers (updated on a tick, then held for CLK_DIV clks):
  - blank <= active.
  - If active and pix_valid: pixel_r/g/b <= pix_data.
  - Otherwise: pixel_r/g/b <= 0.
  - hsync <= HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; else ~HS_POL.
  - vsync follows the same rule on v with V_* parameters and VS_POL.
- Latency: one clk from tick to pins; outputs correspond to the pre-increment counter values.
- comp_sync: when SOG=1, comp_sync <= ~(hs_asserted | vs_asserted), active-low composite. When SOG=0 it is held at 0.
- frame_start: registered one-clk pulse on the tick where h=0 and v=0.
- underflow: set on a tick where active and !pix_valid; that pixel outputs black.
  - Cleared by underflow_clr.
  - If set and clear occur in the same clk, set wins.
- Asserting reset mid-frame restarts the frame at h=0, v=0. No pixel is consumed while rst=0.

Decomposition:
- Shared package vga_pkg: the default 640x480@60 timing constants, an SVGA 800x600 set, and a clog2 helper function.
- One natural sub-module: vga_axis_counter, a parametrised total/active/fp/sync/pol counter producing count, wrap, active and sync. It is instantiated twice: h is enabled by tick, v by tick & h_wrap.

Test Plan:
- Bench parameters: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=4, HS/VS_POL=0.
- Reset values: hold rst=0, toggle pix_valid -> pix_ready=0, hsync=1, vsync=1, blank=0, pixels=0. Release rst -> first tick at clk 4.
- Line timing: pix_valid=1 constant -> blank=1 for 8 ticks (32 clks). hsync=0 during ticks h=10..12. Line period is 64 clks.
- Frame timing: vsync=0 for lines 5..6. frame_start pulses every 512 clks.
- Data path: drive an incrementing pix_data 0x000001.. -> exactly 32 pix_ready pulses per frame. The pixel sequence appears in order, one tick per pixel.
- Underflow: drop pix_valid at h=3, v=1 -> that pixel outputs black and underflow=1 until cleared. Pulse underflow_clr together with a new underflow -> flag stays 1.
- Mid-frame reset: assert rst at h=5, v=2 -> counters return to 0 and outputs return to reset values. frame_start fires 4 clks after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and a constant-width helper.
// Used by the axis counters and the timing controller top.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with active and sync decode.
// Instantiated once per axis by vga_timing_ctrl.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL  = 800,
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter logic POL    = 1'b0,
    parameter int   W      = clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_on,
    output logic         sync
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [31:0]  pos;

    assign pos = 32'(count_q);

    always_comb begin
        wrap    = (pos == 32'(TOTAL - 1));
        active  = (pos < 32'(ACTIVE));
        sync_on = (pos >= 32'(ACTIVE + FP)) &&
                  (pos < 32'(ACTIVE + FP + SYNC));
        sync    = sync_on ? POL : ~POL;
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA timing generator with clock-enable pixel divider,
// valid/ready pixel intake, registered DAC outputs and underflow flag.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 4,
    parameter int   COLOR_W  = 8,
    parameter logic SOG      = 1'b0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW       = clog2(H_TOTAL),
    localparam int  VW       = clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid,
    input  logic [3*COLOR_W-1:0] pix_data,
    output logic                 pix_ready,
    input  logic                 underflow_clr,
    output logic                 frame_start,
    output logic                 underflow,
    output logic [HW-1:0]        h_count,
    output logic [VW-1:0]        v_count,
    output logic                 blank,
    output logic                 comp_sync,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   pixel_r,
    output logic [COLOR_W-1:0]   pixel_g,
    output logic [COLOR_W-1:0]   pixel_b
);

    localparam int DW = clog2(CLK_DIV);
    localparam int PW = 3 * COLOR_W;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic          h_wrap, h_active, h_sync_on, h_sync;
    logic          v_wrap_unused, v_active, v_sync_on, v_sync;
    logic          active;

    logic          blank_q, blank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          comp_sync_q, comp_sync_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;
    logic [PW-1:0] pix_q, pix_d;

    assign tick = (32'(div_q) == 32'(CLK_DIV - 1));

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP),
        .SYNC(H_SYNC), .POL(HS_POL), .W(HW)
    ) u_h (
        .clk(clk), .rst(rst), .en(tick),
        .count(h_count), .wrap(h_wrap), .active(h_active),
        .sync_on(h_sync_on), .sync(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP),
        .SYNC(V_SYNC), .POL(VS_POL), .W(VW)
    ) u_v (
        .clk(clk), .rst(rst), .en(tick & h_wrap),
        .count(v_count), .wrap(v_wrap_unused), .active(v_active),
        .sync_on(v_sync_on), .sync(v_sync)
    );

    assign active    = h_active & v_active;
    assign pix_ready = tick & active & pix_valid;

    always_comb begin
        div_d         = tick ? '0 : div_q + DW'(1);
        blank_d       = blank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        comp_sync_d   = comp_sync_q;
        pix_d         = pix_q;
        frame_start_d = 1'b0;
        underflow_d   = underflow_q;
        // Outputs describe the position before this tick's increment.
        if (tick) begin
            blank_d       = active;
            pix_d         = (active && pix_valid) ? pix_data : '0;
            hsync_d       = h_sync;
            vsync_d       = v_sync;
            comp_sync_d   = SOG & ~(h_sync_on | v_sync_on);
            frame_start_d = (h_count == '0) && (v_count == '0);
        end
        if (tick && active && !pix_valid) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            blank_q       <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            comp_sync_q   <= SOG;
            pix_q         <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            comp_sync_q   <= comp_sync_d;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign comp_sync   = comp_sync_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign pixel_r     = pix_q[3*COLOR_W-1:2*COLOR_W];
    assign pixel_g     = pix_q[2*COLOR_W-1:COLOR_W];
    assign pixel_b     = pix_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a small 16x8 raster.
// Expected outputs come from an absolute-clock-count reference model.
module tb_vga_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int DIV = 4;
    localparam int CW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_ready, frame_start, underflow;
    logic [3:0]  h_count;
    logic [2:0]  v_count;
    logic        blank, comp_sync, hsync, vsync;
    logic [7:0]  pixel_r, pixel_g, pixel_b;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DIV),
        .COLOR_W(CW), .SOG(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready),
        .underflow_clr(underflow_clr), .frame_start(frame_start),
        .underflow(underflow), .h_count(h_count), .v_count(v_count),
        .blank(blank), .comp_sync(comp_sync), .hsync(hsync),
        .vsync(vsync), .pixel_r(pixel_r), .pixel_g(pixel_g),
        .pixel_b(pixel_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        blank;
        logic        hsync;
        logic        vsync;
        logic        comp_sync;
        logic        frame_start;
        logic        underflow;
        logic [23:0] pix;
        logic [3:0]  h;
        logic [2:0]  v;
    } obs_t;

    obs_t exp_q[$];
    logic rdy_q[$];
    int   checks = 0;
    int   passed = 0;

    int          m = 0;
    obs_t        cur;
    logic [23:0] d;
    bit          last_rdy = 0;
    bit          full_mode = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    endtask

    function automatic obs_t reset_obs();
        obs_t r;
        r = '0;
        r.hsync = 1'b1;
        r.vsync = 1'b1;
        r.comp_sync = 1'b1;
        return r;
    endfunction

    function automatic int pos_h();
        return (m / DIV) % HT;
    endfunction

    function automatic int pos_v();
        return (m / DIV / HT) % VT;
    endfunction

    function automatic bit is_tick();
        return (m % DIV) == DIV - 1;
    endfunction

    // Predict pix_ready now and all registered pins after the next edge.
    task automatic model();
        int  h, v;
        bit  tk, act, hs_on, vs_on;
        last_rdy = 0;
        if (!rst) begin
            cur = reset_obs();
            m = 0;
        end else begin
            h = pos_h();
            v = pos_v();
            tk = is_tick();
            act = (h < HA) && (v < VA);
            last_rdy = tk && act && pix_valid;
            cur.frame_start = 1'b0;
            if (tk) begin
                hs_on = (h >= HA + HF) && (h < HA + HF + HS);
                vs_on = (v >= VA + VF) && (v < VA + VF + VS);
                cur.blank = act;
                cur.pix = (act && pix_valid) ? pix_data : 24'h0;
                cur.hsync = !hs_on;
                cur.vsync = !vs_on;
                cur.comp_sync = !(hs_on || vs_on);
                cur.frame_start = (h == 0) && (v == 0);
            end
            if (tk && act && !pix_valid) cur.underflow = 1'b1;
            else if (underflow_clr) cur.underflow = 1'b0;
            m++;
            cur.h = 4'(pos_h());
            cur.v = 3'(pos_v());
        end
        rdy_q.push_back(last_rdy);
        exp_q.push_back(cur);
    endtask

    task automatic cyc(input logic v, input logic [23:0] dat,
                       input logic clr, input logic r);
        @(negedge clk);
        rst = r;
        pix_valid = v;
        pix_data = dat;
        underflow_clr = clr;
        model();
    endtask

    task automatic run_valid(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, d, 1'b0, 1'b1);
            if (last_rdy) d++;
        end
    endtask

    obs_t e_mon, a_mon;
    logic r_mon;
    int   rdy_cnt = 0, clk_cnt = 0, since_rel = 0;
    bit   armed = 0, window_ok = 0, first_pending = 1;

    always @(negedge clk) begin
        #2;
        if (rdy_q.size() > 0) begin
            r_mon = rdy_q.pop_front();
            chk("pix_ready", 64'(pix_ready), 64'(r_mon));
        end
        if (pix_ready) rdy_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            a_mon = {blank, hsync, vsync, comp_sync, frame_start,
                     underflow, pixel_r, pixel_g, pixel_b,
                     h_count, v_count};
            chk("pins", 64'(a_mon), 64'(e_mon));
        end
        if (!rst) begin
            armed = 0;
            since_rel = 0;
            first_pending = 1;
            rdy_cnt = 0;
            clk_cnt = 0;
        end else begin
            since_rel++;
            clk_cnt++;
            if (!full_mode) window_ok = 0;
            if (frame_start) begin
                if (first_pending) begin
                    chk("fs_after_release", 64'(since_rel), 64'(DIV));
                    first_pending = 0;
                end
                if (armed && window_ok) begin
                    chk("frame_pixels", 64'(rdy_cnt), 64'(HA * VA));
                    chk("frame_clks", 64'(clk_cnt), 64'(HT * VT * DIV));
                end
                armed = 1;
                window_ok = full_mode;
                rdy_cnt = 0;
                clk_cnt = 0;
            end
        end
    end

    initial begin
        bit          nv, nc;
        int          k;
        cur = reset_obs();
        d = 24'h1;

        for (int i = 0; i < 8; i++) cyc(i[0], 24'h0, 1'b0, 1'b0);

        full_mode = 1;
        run_valid(3 * HT * VT * DIV + 16);
        full_mode = 0;

        k = 0;
        while (k < 1024 && !(pos_h() == 3 && pos_v() == 1 && is_tick())) begin
            run_valid(1);
            k++;
        end
        cyc(1'b0, d, 1'b0, 1'b1);
        run_valid(40);

        k = 0;
        while (k < 1024 && !(pos_h() < HA && pos_v() < VA && is_tick())) begin
            run_valid(1);
            k++;
        end
        cyc(1'b0, d, 1'b1, 1'b1);
        cyc(1'b1, d, 1'b1, 1'b1);
        run_valid(20);

        for (int i = 0; i < 3 * HT * VT * DIV; i++) begin
            if (last_rdy || !pix_valid) d = 24'($urandom());
            nv = ($urandom_range(0, 9) != 0);
            nc = ($urandom_range(0, 19) == 0);
            cyc(nv, d, nc, 1'b1);
        end

        k = 0;
        while (k < 1024 && !(pos_h() == 5 && pos_v() == 2)) begin
            run_valid(1);
            k++;
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, d, 1'b0, 1'b0);
        run_valid(HT * VT * DIV + 40);

        repeat (2) @(posedge clk);
        #3;
        chk("queues_drained", 64'(exp_q.size() + rdy_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
